// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI command decoder and 8-bit register bank with a fabric port.
//
// state   | meaning
// S_IDLE  | no frame; waits for cs_active to rise
// S_CMD   | frame open; next byte is the command
// S_WRITE | data bytes are written at addr_q
// S_READ  | data bytes are discarded; reads stream out
module spi_reg_bank #(
  parameter int         NREGS     = 16,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] STATUS_ID = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_active,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic              fab_we,
  input  logic [7:0]        fab_wdata,
  output logic [7:0]        fab_rdata,
  output logic              fab_collide,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inc_q, inc_d;
  logic              cs_prev_q, cs_prev_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_load_q, tx_load_d;
  logic [7:0]        fab_rdata_q, fab_rdata_d;
  logic              fab_collide_q, fab_collide_d;
  logic              err_q, err_d;
  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];

  logic              cs_rise, cs_fall, byte_ok, spi_we;
  logic [ADDR_W-1:0] next_addr, cmd_addr;
  logic              unused_rx;

  // A byte arriving on the cycle CS drops still belongs to the frame.
  assign cs_rise   = cs_active & ~cs_prev_q;
  assign cs_fall   = ~cs_active & cs_prev_q;
  assign byte_ok   = rx_valid & (cs_active | cs_prev_q);
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign unused_rx = ^rx_byte;

  // Next-state, register-bank and output computation.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    inc_d         = inc_q;
    cs_prev_d     = cs_active;
    tx_byte_d     = tx_byte_q;
    tx_load_d     = 1'b0;
    fab_rdata_d   = regs_q[fab_addr];
    fab_collide_d = 1'b0;
    err_d         = err_q;
    regs_d        = regs_q;
    spi_we        = 1'b0;
    next_addr     = inc_q ? addr_q + ADDR_W'(1) : addr_q;

    if (rx_valid && !cs_active && !cs_prev_q) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cs_rise) begin
          state_d   = S_CMD;
          tx_byte_d = STATUS_ID;
          tx_load_d = 1'b1;
        end
      end
      S_CMD: begin
        if (byte_ok) begin
          addr_d    = cmd_addr;
          inc_d     = rx_byte[6];
          state_d   = rx_byte[7] ? S_WRITE : S_READ;
          tx_byte_d = regs_q[cmd_addr];
          tx_load_d = 1'b1;
        end
      end
      S_READ: begin
        if (byte_ok) begin
          addr_d    = next_addr;
          tx_byte_d = regs_q[next_addr];
          tx_load_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (byte_ok) begin
          spi_we          = 1'b1;
          regs_d[addr_q]  = rx_byte;
          addr_d          = next_addr;
          // Pre-write value: regs_q is read before this edge commits.
          tx_byte_d       = regs_q[next_addr];
          tx_load_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fab_we) begin
      if (spi_we && (addr_q == fab_addr)) fab_collide_d = 1'b1;
      else regs_d[fab_addr] = fab_wdata;
    end

    if (cs_fall) state_d = S_IDLE;
  end

  // All state registers; cs_prev resets high so a frame already open at reset release is skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      inc_q         <= 1'b0;
      cs_prev_q     <= 1'b1;
      tx_byte_q     <= 8'h00;
      tx_load_q     <= 1'b0;
      fab_rdata_q   <= RESET_VAL;
      fab_collide_q <= 1'b0;
      err_q         <= 1'b0;
      regs_q        <= '{default: RESET_VAL};
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      inc_q         <= inc_d;
      cs_prev_q     <= cs_prev_d;
      tx_byte_q     <= tx_byte_d;
      tx_load_q     <= tx_load_d;
      fab_rdata_q   <= fab_rdata_d;
      fab_collide_q <= fab_collide_d;
      err_q         <= err_d;
      regs_q        <= regs_d;
    end
  end

  assign tx_byte     = tx_byte_q;
  assign tx_load     = tx_load_q;
  assign fab_rdata   = fab_rdata_q;
  assign fab_collide = fab_collide_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: frame-level reference model plus directed SPI/fabric vectors.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_active;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [3:0] fab_addr;
  logic       fab_we;
  logic [7:0] fab_wdata;
  logic [7:0] fab_rdata;
  logic       fab_collide;
  logic       err;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .cs_active(cs_active), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_load(tx_load),
    .fab_addr(fab_addr), .fab_we(fab_we), .fab_wdata(fab_wdata),
    .fab_rdata(fab_rdata), .fab_collide(fab_collide), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: a frame is an open flag plus a byte count; byte 0 is the command.
  logic [7:0] m_regs [16];
  logic [7:0] m_tx, m_rdata;
  logic       m_load, m_col, m_err, m_open, m_prev, m_wr, m_inc, m_valid = 1'b0;
  int         m_n, m_ptr;

  always @(posedge clk) begin
    logic       wrote;
    int         wa;
    logic [7:0] wd, rd_next;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_tx = 8'h00; m_load = 0; m_rdata = 8'h00; m_col = 0; m_err = 0;
      m_open = 0; m_prev = 1; m_n = 0; m_ptr = 0; m_wr = 0; m_inc = 0;
    end else begin
      m_load = 0; m_col = 0; wrote = 0; wa = 0; wd = 8'h00;
      rd_next = m_regs[fab_addr];
      if (rx_valid) begin
        if (!cs_active && !m_prev) m_err = 1;
        else if (m_open) begin
          if (m_n == 0) begin
            m_wr = rx_byte[7]; m_inc = rx_byte[6]; m_ptr = rx_byte % 16;
          end else begin
            if (m_wr) begin wrote = 1; wa = m_ptr; wd = rx_byte; end
            if (m_inc) m_ptr = (m_ptr + 1) % 16;
          end
          m_tx = m_regs[m_ptr];
          m_n++;
          m_load = 1;
        end
      end
      if (fab_we) begin
        if (wrote && wa == int'(fab_addr)) m_col = 1;
        else m_regs[fab_addr] = fab_wdata;
      end
      if (wrote) m_regs[wa] = wd;
      if (!m_prev && cs_active) begin
        m_open = 1; m_n = 0; m_tx = 8'h5A; m_load = 1;
      end
      if (m_prev && !cs_active) m_open = 0;
      m_rdata = rd_next;
      m_prev  = cs_active;
    end
    m_valid = 1;
  end

  logic [7:0] txlog [$];
  int         nload = 0;
  int         ncol  = 0;

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("tx_load", {7'b0, tx_load}, {7'b0, m_load});
      chk("tx_byte", tx_byte, m_tx);
      chk("fab_rdata", fab_rdata, m_rdata);
      chk("fab_collide", {7'b0, fab_collide}, {7'b0, m_col});
      chk("err", {7'b0, err}, {7'b0, m_err});
    end
    if (tx_load) begin txlog.push_back(tx_byte); nload++; end
    if (fab_collide) ncol++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    cyc(3);
  endtask

  task automatic cs_on;
    txlog.delete();
    cs_active = 1'b1;
    cyc(3);
  endtask

  task automatic cs_off;
    cs_active = 1'b0;
    cyc(3);
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] exp_v, input string name);
    fab_addr = a;
    cyc(2);
    chk(name, fab_rdata, exp_v);
  endtask

  task automatic check_log(input string name, input int n, input logic [63:0] v);
    chk({name, "_len"}, 8'(txlog.size()), 8'(n));
    for (int i = 0; i < n && i < txlog.size(); i++)
      chk(name, txlog[i], v[8*(n-1-i) +: 8]);
  endtask

  initial begin
    int snap;
    rst = 1'b1; cs_active = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
    fab_addr = 4'd0; fab_we = 1'b0; fab_wdata = 8'h00;
    cyc(3);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_tx_load", {7'b0, tx_load}, 8'h00);
    chk("rst_fab_rdata", fab_rdata, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    rst = 1'b0;
    cyc(2);

    // Auto-increment write at 2.
    cs_on; send(8'hC2); send(8'h11); send(8'h22); send(8'h33); cs_off;
    check_log("wr_inc_log", 5, 64'h5A00000000);
    peek(4'd3, 8'h22, "wr_inc_r3");
    peek(4'd2, 8'h11, "wr_inc_r2");
    peek(4'd4, 8'h33, "wr_inc_r4");

    // Auto-increment read at 2.
    cs_on; send(8'h42); send(8'h00); send(8'h00); send(8'h00); cs_off;
    check_log("rd_inc_log", 5, 64'h5A11223300);
    peek(4'd3, 8'h22, "rd_keep_r3");

    // Wrap 15 -> 0.
    cs_on; send(8'hCF); send(8'hAA); send(8'hBB); cs_off;
    peek(4'd15, 8'hAA, "wrap_r15");
    peek(4'd0, 8'hBB, "wrap_r0");

    // Fixed address; tx shows pre-write values.
    cs_on; send(8'h85); send(8'h01); send(8'h02); send(8'h03); cs_off;
    check_log("noinc_log", 5, 64'h5A00000102);
    peek(4'd5, 8'h03, "noinc_r5");

    // Collision at 7: SPI wins.
    snap = ncol;
    cs_on; send(8'hC7);
    rx_byte = 8'h77; rx_valid = 1'b1; fab_we = 1'b1; fab_addr = 4'd7; fab_wdata = 8'hFF;
    @(negedge clk);
    rx_valid = 1'b0; fab_we = 1'b0;
    cyc(3); cs_off;
    chk("collide_pulses", 8'(ncol - snap), 8'd1);
    peek(4'd7, 8'h77, "collide_r7");

    // Different addresses: both commit.
    snap = ncol;
    cs_on; send(8'h87);
    rx_byte = 8'h44; rx_valid = 1'b1; fab_we = 1'b1; fab_addr = 4'd8; fab_wdata = 8'h99;
    @(negedge clk);
    rx_valid = 1'b0; fab_we = 1'b0;
    cyc(3); cs_off;
    chk("nocollide_pulses", 8'(ncol - snap), 8'd0);
    peek(4'd7, 8'h44, "nocollide_r7");
    peek(4'd8, 8'h99, "nocollide_r8");

    // Data byte on the CS-falling cycle.
    cs_on; send(8'hC9);
    rx_byte = 8'h66; rx_valid = 1'b1; cs_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    cyc(3);
    check_log("csfall_log", 3, 64'h5A0000);
    peek(4'd9, 8'h66, "csfall_r9");
    chk("csfall_no_err", {7'b0, err}, 8'h00);
    cs_on; cs_off;
    check_log("csfall_idle_log", 1, 64'h5A);

    // Byte outside a frame: sticky err.
    send(8'h12);
    chk("err_set", {7'b0, err}, 8'h01);
    cyc(10);
    chk("err_sticky", {7'b0, err}, 8'h01);
    cs_on; send(8'h40); cs_off;
    chk("err_sticky2", {7'b0, err}, 8'h01);

    // Reset mid-frame: stay quiet until CS toggles.
    cs_on; send(8'hC0);
    rst = 1'b1; cyc(2); rst = 1'b0;
    snap = nload;
    send(8'h55); send(8'h56); cyc(3);
    chk("rstmid_no_load", 8'(nload - snap), 8'd0);
    peek(4'd0, 8'h00, "rstmid_r0");
    chk("rstmid_err_clr", {7'b0, err}, 8'h00);
    cs_off;
    cs_on; cs_off;
    check_log("rstmid_new_frame", 1, 64'h5A);

    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
